// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read data memory (core priority, bounded host wait, host lock).
// Optional ARB_STATS_EN adds conflict_cnt / force_cnt statistics outputs.
module data_mem_arbiter #(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 8,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              host_lock,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_locked,
`ifdef ARB_STATS_EN
   output logic [15:0]       conflict_cnt,
   output logic [15:0]       force_cnt,
`endif
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // state  | meaning
   // ARB    | per-cycle arbitration, core priority, host forced after HOST_MAX_WAIT denials
   // LOCKED | host owns the memory; core always denied until host_lock drops

   typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

   localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

   state_t            state, state_nxt;
   logic [3:0]        wait_cnt, wait_nxt;
   logic              host_forced;
   logic              rd_pending;
   logic              rd_owner;
   logic [DATA_W-1:0] core_rdata_q;
   logic [DATA_W-1:0] host_rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_ARB;
         wait_cnt     <= '0;
         rd_pending   <= 1'b0;
         rd_owner     <= 1'b0;
         core_rdata_q <= '0;
         host_rdata_q <= '0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_nxt;
         rd_pending <= mem_en & ~mem_we;
         rd_owner   <= host_gnt;
         if (core_rvalid) core_rdata_q <= mem_rdata;
         if (host_rvalid) host_rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      core_gnt    = 1'b0;
      host_gnt    = 1'b0;
      host_forced = 1'b0;
      if (!reset) begin
         case (state)
            ST_ARB: begin
               if (core_req && host_req) begin
                  if (wait_cnt >= MAX_WAIT) begin
                     host_gnt    = 1'b1;
                     host_forced = 1'b1;
                  end else begin
                     core_gnt = 1'b1;
                  end
               end else begin
                  core_gnt = core_req;
                  host_gnt = host_req;
               end
               if (host_gnt && host_lock) state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
               host_gnt = host_req;
               if (!host_lock) state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
         endcase
         if (host_gnt || !host_req)
            wait_nxt = '0;
         else if (core_gnt && wait_cnt < MAX_WAIT)
            wait_nxt = wait_cnt + 4'd1;
      end
   end

   always_comb begin
      mem_en    = core_gnt | host_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (host_gnt) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end else if (core_gnt) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end
   end

   // Read data is taken straight from the memory on the return cycle and held afterwards.
   always_comb begin
      core_rvalid = rd_pending & ~rd_owner & ~reset;
      host_rvalid = rd_pending &  rd_owner & ~reset;
      core_rdata  = reset ? '0 : (core_rvalid ? mem_rdata : core_rdata_q);
      host_rdata  = reset ? '0 : (host_rvalid ? mem_rdata : host_rdata_q);
      core_stall  = core_req & ~core_gnt & ~reset;
      host_locked = (state == ST_LOCKED);
   end

`ifdef ARB_STATS_EN
   // A starvation-forced host grant is the intended outcome, so it is not counted as a conflict.
   logic conflict_evt;
   assign conflict_evt = core_req & host_req & ~host_forced & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt <= '0;
         force_cnt    <= '0;
      end else begin
         if (conflict_evt && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
         if (host_forced && force_cnt != 16'hFFFF)     force_cnt    <= force_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model with its own reference memory.
module tb_data_mem_arbiter;
   localparam int MAXW = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       core_req = 1'b0, core_we = 1'b0;
   logic [7:0] core_addr = 8'h00, core_wdata = 8'h00;
   logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
   logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
   logic       core_gnt, core_rvalid, core_stall;
   logic [7:0] core_rdata;
   logic       host_gnt, host_rvalid, host_locked;
   logic [7:0] host_rdata;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata;
   logic [7:0] mem_rdata = 8'h00;
`ifdef ARB_STATS_EN
   logic [15:0] conflict_cnt, force_cnt;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .HOST_MAX_WAIT(MAXW)) dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .host_locked(host_locked),
`ifdef ARB_STATS_EN
      .conflict_cnt(conflict_cnt), .force_cnt(force_cnt),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory array driven by the DUT's memory port.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: ownership flag, denial count, one-deep return slot, reference memory.
   logic [7:0] ref_mem [256];
   bit         m_locked = 0;
   int         m_wait = 0;
   bit         m_ret_v = 0, m_ret_host = 0;
   logic [7:0] m_ret_data = 8'h00, m_core_last = 8'h00, m_host_last = 8'h00;
   int         m_conf = 0, m_force = 0;

   bit         eg_c, eg_h, e_forced, e_crv, e_hrv, e_we;
   logic [7:0] e_addr, e_wdata;

   always @(negedge clk) begin
      eg_c = 0; eg_h = 0; e_forced = 0;
      if (!reset) begin
         if (m_locked) eg_h = host_req;
         else if (core_req && host_req) begin
            if (m_wait == MAXW) begin eg_h = 1; e_forced = 1; end
            else eg_c = 1;
         end else begin
            eg_c = core_req;
            eg_h = host_req;
         end
      end
      e_crv   = !reset && m_ret_v && !m_ret_host;
      e_hrv   = !reset && m_ret_v && m_ret_host;
      e_we    = eg_h ? host_we    : (eg_c ? core_we    : 1'b0);
      e_addr  = eg_h ? host_addr  : (eg_c ? core_addr  : 8'h00);
      e_wdata = eg_h ? host_wdata : (eg_c ? core_wdata : 8'h00);

      chk("core_gnt", core_gnt, eg_c);
      chk("host_gnt", host_gnt, eg_h);
      chk("core_stall", core_stall, !reset && core_req && !eg_c);
      chk("mem_en", mem_en, eg_c || eg_h);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("host_locked", host_locked, m_locked);
      chk("core_rvalid", core_rvalid, e_crv);
      chk("host_rvalid", host_rvalid, e_hrv);
      chk("core_rdata", core_rdata, reset ? 8'h00 : (e_crv ? m_ret_data : m_core_last));
      chk("host_rdata", host_rdata, reset ? 8'h00 : (e_hrv ? m_ret_data : m_host_last));
`ifdef ARB_STATS_EN
      chk("conflict_cnt", conflict_cnt, m_conf);
      chk("force_cnt", force_cnt, m_force);
`endif

      if (reset) begin
         m_locked = 0; m_wait = 0; m_ret_v = 0;
         m_core_last = 8'h00; m_host_last = 8'h00;
         m_conf = 0; m_force = 0;
      end else begin
         if (e_crv) m_core_last = m_ret_data;
         if (e_hrv) m_host_last = m_ret_data;
         m_ret_v    = (eg_c && !core_we) || (eg_h && !host_we);
         m_ret_host = eg_h;
         m_ret_data = eg_h ? ref_mem[host_addr] : ref_mem[core_addr];
         if (eg_h && host_we) ref_mem[host_addr] = host_wdata;
         if (eg_c && core_we) ref_mem[core_addr] = core_wdata;
         if (core_req && host_req && !e_forced && m_conf < 65535) m_conf++;
         if (e_forced && m_force < 65535) m_force++;
         if (eg_h || !host_req) m_wait = 0;
         else if (core_req && m_wait < MAXW) m_wait++;
         if (m_locked) begin
            if (!host_lock) m_locked = 0;
         end else if (eg_h && host_lock) m_locked = 1;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req = 0; core_we = 0; core_addr = 8'h00; core_wdata = 8'h00;
      host_req = 0; host_we = 0; host_addr = 8'h00; host_wdata = 8'h00; host_lock = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8'h40]     = 8'h5A;
      ref_mem[8'h40] = 8'h5A;

      // reset with core requesting
      reset = 1; core_req = 1; core_addr = 8'h10;
      for (int i = 0; i < 2; i++) begin
         cyc(); #1;
         chk("rst_core_gnt", core_gnt, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_core_rvalid", core_rvalid, 0);
      end
      cyc(); reset = 0; #1;
      chk("rel_core_gnt", core_gnt, 1);

      // core read of 0x40
      cyc(); core_req = 1; core_we = 0; core_addr = 8'h40; #1;
      chk("rd_core_gnt", core_gnt, 1);
      cyc(); core_req = 0; #1;
      chk("rd_rvalid_n1", core_rvalid, 1);
      chk("rd_rdata_n1", core_rdata, 8'h5A);
      cyc(); #1;
      chk("rd_rvalid_n2", core_rvalid, 0);
      chk("rd_rdata_hold", core_rdata, 8'h5A);

      // starvation
      for (int i = 0; i < 6; i++) begin
         cyc(); core_req = 1; core_addr = 8'h42; host_req = 1; host_we = 0; host_addr = 8'h41; #1;
         chk("starve_core_gnt", core_gnt, i != 4);
         chk("starve_host_gnt", host_gnt, i == 4);
         chk("starve_stall", core_stall, i == 4);
      end

      // lock burst, host wins the port by starvation then keeps it
      cyc(); idle(); #1;
      for (int i = 0; i < 4; i++) begin
         cyc(); core_req = 1; core_we = 0; core_addr = 8'h02;
         host_req = 1; host_we = 1; host_lock = 1; host_addr = 8'h00; host_wdata = 8'h01; #1;
         chk("lock_pre_core_gnt", core_gnt, 1);
      end
      for (int k = 0; k < 4; k++) begin
         cyc(); host_addr = 8'(k); host_wdata = 8'(k + 1); #1;
         chk("lock_host_gnt", host_gnt, 1);
         chk("lock_stall", core_stall, 1);
      end
      cyc(); host_lock = 0; host_req = 0; #1;
      chk("unlock_core_gnt", core_gnt, 0);
      chk("unlock_locked", host_locked, 1);
      cyc(); #1;
      chk("post_lock_core_gnt", core_gnt, 1);
      chk("post_lock_locked", host_locked, 0);
      cyc(); core_req = 0; #1;
      chk("post_lock_rvalid", core_rvalid, 1);
      chk("post_lock_rdata", core_rdata, 8'h03);

      // reset during an in-flight host read
      cyc(); idle(); host_req = 1; host_addr = 8'h40; #1;
      chk("mid_host_gnt", host_gnt, 1);
      cyc(); host_req = 0; reset = 1; #1;
      chk("mid_rst_rvalid", host_rvalid, 0);
      chk("mid_rst_rdata", host_rdata, 8'h00);
      cyc(); reset = 0; #1;
      chk("mid_after_rvalid", host_rvalid, 0);
      chk("mid_after_locked", host_locked, 0);

      // ten starvation cycles from cleared statistics
      for (int i = 0; i < 10; i++) begin
         cyc(); core_req = 1; host_req = 1; host_we = 0; #1;
         chk("stat_host_gnt", host_gnt, (i == 4) || (i == 9));
      end
      cyc(); idle(); #1;
`ifdef ARB_STATS_EN
      chk("stat_conflict", conflict_cnt, 8);
      chk("stat_force", force_cnt, 2);
`endif

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset      = ($urandom_range(63) == 0);
         core_req   = ($urandom_range(3) != 0);
         core_we    = 1'($urandom);
         core_addr  = 8'($urandom_range(15));
         core_wdata = 8'($urandom);
         host_req   = ($urandom_range(2) != 0);
         host_we    = 1'($urandom);
         host_addr  = 8'($urandom_range(15));
         host_wdata = 8'($urandom);
         if ($urandom_range(7) == 0) host_lock = !host_lock;
      end
      cyc(); idle(); reset = 0;
      cyc();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
